bsram_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one byte-enabled, same-cycle-read BSRAM (separate read and write ports) between two requesters, e.g. core data port and DMA/debug port.
- Accepts at most one transaction per cycle using a valid/ready handshake, drives the BSRAM ports combinationally from the granted request, and returns a registered response one cycle later.
- Sits between requester logic and the BSRAM instance inside a core's memory subsystem.

---
 rtl/bsram_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_bsram_rr_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsram_rr_arbiter.sv
// Two-requester round-robin front end for a byte-enabled, same-cycle-read BSRAM.
// Optional power-on clear of the whole array: define BSRAM_ARB_INIT_CLEAR_EN.
module bsram_rr_arbiter #(
    parameter int unsigned           CORE       = 0,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [1:0]                    reqValid,
    output logic [1:0]                    reqReady,
    input  logic [1:0]                    reqWrite,
    input  logic [2*(DATA_WIDTH/8)-1:0]   reqByteEnable,
    input  logic [2*ADDR_WIDTH-1:0]       reqAddress,
    input  logic [2*DATA_WIDTH-1:0]       reqWriteData,
    output logic [1:0]                    respValid,
    output logic [2*DATA_WIDTH-1:0]       respData,
    output logic                          memReadEnable,
    output logic [ADDR_WIDTH-1:0]         memReadAddress,
    input  logic [DATA_WIDTH-1:0]         memReadData,
    output logic                          memWriteEnable,
    output logic [DATA_WIDTH/8-1:0]       memWriteByteEnable,
    output logic [ADDR_WIDTH-1:0]         memWriteAddress,
    output logic [DATA_WIDTH-1:0]         memWriteData,
    output logic                          initDone
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0) begin : gBadWidth
        $error("bsram_rr_arbiter core %0d: DATA_WIDTH must be a multiple of 8", CORE);
    end

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} arbState_e;

`ifdef BSRAM_ARB_INIT_CLEAR_EN
    localparam arbState_e RESET_STATE = INIT;
`else
    localparam arbState_e RESET_STATE = RUN;
`endif

    arbState_e             state, nextState;
    logic                  pointer, nextPointer;
    logic [ADDR_WIDTH-1:0] initCount, nextInitCount;
    logic [1:0]            grant;
    logic                  selSlot;
    logic                  selWrite;
    logic [ADDR_WIDTH-1:0] selAddress;
    logic [BE_WIDTH-1:0]   selByteEnable;
    logic [DATA_WIDTH-1:0] selWriteData;

    // State, priority pointer and clear counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RESET_STATE;
            pointer   <= 1'b0;
            initCount <= '0;
        end else begin
            state     <= nextState;
            pointer   <= nextPointer;
            initCount <= nextInitCount;
        end
    end

    // Arbitration, next state and BSRAM port drive.
    always_comb begin
        nextState          = state;
        nextPointer        = pointer;
        nextInitCount      = initCount;
        grant              = 2'b00;
        memReadEnable      = 1'b0;
        memReadAddress     = '0;
        memWriteEnable     = 1'b0;
        memWriteByteEnable = '0;
        memWriteAddress    = '0;
        memWriteData       = '0;

        case (state)
            INIT: begin
                memWriteEnable     = 1'b1;
                memWriteByteEnable = '1;
                memWriteAddress    = initCount;
                memWriteData       = INIT_VALUE;
                nextInitCount      = ADDR_WIDTH'(initCount + 1'b1);
                if (initCount == {ADDR_WIDTH{1'b1}}) begin
                    nextState = RUN;
                end
            end
            default: begin
                if (reqValid == 2'b11) begin
                    grant = pointer ? 2'b10 : 2'b01;
                end else begin
                    grant = reqValid;
                end
            end
        endcase

        selSlot       = grant[1];
        selWrite      = selSlot ? reqWrite[1] : reqWrite[0];
        selAddress    = selSlot ? reqAddress[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                                : reqAddress[ADDR_WIDTH-1:0];
        selByteEnable = selSlot ? reqByteEnable[2*BE_WIDTH-1 -: BE_WIDTH]
                                : reqByteEnable[BE_WIDTH-1:0];
        selWriteData  = selSlot ? reqWriteData[2*DATA_WIDTH-1 -: DATA_WIDTH]
                                : reqWriteData[DATA_WIDTH-1:0];

        if (grant != 2'b00) begin
            // Hand priority to the requester that was not just served.
            nextPointer = grant[0];
            if (selWrite) begin
                memWriteEnable     = 1'b1;
                memWriteByteEnable = selByteEnable;
                memWriteAddress    = selAddress;
                memWriteData       = selWriteData;
            end else begin
                memReadEnable  = 1'b1;
                memReadAddress = selAddress;
            end
        end
    end

    // One-cycle registered response; the ungranted slice keeps its old data.
    always_ff @(posedge clock) begin
        if (reset) begin
            respValid <= 2'b00;
            respData  <= '0;
        end else begin
            respValid <= grant;
            if (grant[0]) begin
                respData[DATA_WIDTH-1:0] <= reqWrite[0] ? '0 : memReadData;
            end
            if (grant[1]) begin
                respData[2*DATA_WIDTH-1 -: DATA_WIDTH] <= reqWrite[1] ? '0 : memReadData;
            end
        end
    end

    assign reqReady = grant;
    assign initDone = (state == RUN);

endmodule

// File: tb/tb_bsram_rr_arbiter.sv
// Directed bench for bsram_rr_arbiter with a behavioural byte-enabled BSRAM model.
module tb_bsram_rr_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned BW = DW / 8;
    localparam logic [DW-1:0] INIT_VAL = 32'hDEADBEEF;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        reqValid;
    logic [1:0]        reqReady;
    logic [1:0]        reqWrite;
    logic [2*BW-1:0]   reqByteEnable;
    logic [2*AW-1:0]   reqAddress;
    logic [2*DW-1:0]   reqWriteData;
    logic [1:0]        respValid;
    logic [2*DW-1:0]   respData;
    logic              memReadEnable;
    logic [AW-1:0]     memReadAddress;
    logic [DW-1:0]     memReadData;
    logic              memWriteEnable;
    logic [BW-1:0]     memWriteByteEnable;
    logic [AW-1:0]     memWriteAddress;
    logic [DW-1:0]     memWriteData;
    logic              initDone;

    logic [DW-1:0]     mem [1<<AW];
    int                testCount = 0;
    int                failCount = 0;

    bsram_rr_arbiter #(
        .CORE(0), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INIT_VAL)
    ) dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqByteEnable(reqByteEnable), .reqAddress(reqAddress),
        .reqWriteData(reqWriteData), .respValid(respValid), .respData(respData),
        .memReadEnable(memReadEnable), .memReadAddress(memReadAddress),
        .memReadData(memReadData), .memWriteEnable(memWriteEnable),
        .memWriteByteEnable(memWriteByteEnable), .memWriteAddress(memWriteAddress),
        .memWriteData(memWriteData), .initDone(initDone)
    );

    always #5 clock = ~clock;

    // BSRAM model: combinational read, byte-enabled write at the clock edge.
    assign memReadData = mem[memReadAddress];
    always @(posedge clock) begin
        if (memWriteEnable) begin
            for (int b = 0; b < int'(BW); b++) begin
                if (memWriteByteEnable[b]) mem[memWriteAddress][8*b +: 8] <= memWriteData[8*b +: 8];
            end
        end
    end

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setReq(input int r, input logic wr, input logic [AW-1:0] addr,
                          input logic [BW-1:0] be, input logic [DW-1:0] data);
        reqWrite[r] = wr;
        reqAddress[r*AW +: AW] = addr;
        reqByteEnable[r*BW +: BW] = be;
        reqWriteData[r*DW +: DW] = data;
    endtask

    // Runs the clear sequence (if built in) and checks its length.
    task automatic waitReady();
`ifdef BSRAM_ARB_INIT_CLEAR_EN
        int n;
        n = 0;
        checkValue("initDoneLow", 64'(initDone), 64'd0);
        checkValue("initFirstAddr", 64'(memWriteAddress), 64'd0);
        checkValue("initWriteEn", 64'(memWriteEnable), 64'd1);
        checkValue("initNoGrant", 64'(reqReady), 64'd0);
        while (!initDone && n < 40) begin
            tick();
            n++;
        end
        checkValue("initCycles", 64'(n), 64'd16);
`else
        checkValue("initDoneHigh", 64'(initDone), 64'd1);
`endif
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        reset = 1'b1;
        reqValid = 2'b00;
        reqWrite = 2'b00;
        reqByteEnable = '0;
        reqAddress = '0;
        reqWriteData = '0;
        tick();
        tick();
        checkValue("resetRespValid", 64'(respValid), 64'd0);
        checkValue("resetRespData0", 64'(respData[DW-1:0]), 64'd0);
        checkValue("resetRespData1", 64'(respData[2*DW-1 -: DW]), 64'd0);

        reset = 1'b0;
        reqValid = 2'b11;
        #1;
        waitReady();
        reqValid = 2'b00;
        #1;
        checkValue("idleReady", 64'(reqReady), 64'd0);
        checkValue("idleMemEn", 64'({memReadEnable, memWriteEnable}), 64'd0);
        checkValue("idleAddr", 64'(memReadAddress), 64'd0);

`ifdef BSRAM_ARB_INIT_CLEAR_EN
        reqValid = 2'b01;
        for (int i = 0; i < 16; i++) begin
            setReq(0, 1'b0, AW'(i), '0, '0);
            tick();
            checkValue("clearRead", 64'(respData[DW-1:0]), 64'hDEADBEEF);
        end
        reqValid = 2'b00;
`endif

        // Single requester: write then read back.
        setReq(0, 1'b1, 4'd5, 4'hF, 32'h11223344);
        reqValid = 2'b01;
        #1;
        checkValue("r0WrReady", 64'(reqReady), 64'h1);
        checkValue("r0WrMem", 64'({memWriteEnable, memReadEnable, memWriteAddress}), 64'h25);
        tick();
        checkValue("r0WrResp", 64'(respValid), 64'h1);
        checkValue("r0WrData", 64'(respData[DW-1:0]), 64'd0);
        setReq(0, 1'b0, 4'd5, 4'h0, 32'h0);
        #1;
        checkValue("r0RdReady", 64'(reqReady), 64'h1);
        checkValue("r0RdMem", 64'({memWriteEnable, memReadEnable, memReadAddress}), 64'h15);
        tick();
        checkValue("r0RdResp", 64'(respValid), 64'h1);
        checkValue("r0RdData", 64'(respData[DW-1:0]), 64'h11223344);

        // Partial byte-enable write from requester 1.
        reqValid = 2'b10;
        setReq(1, 1'b1, 4'd5, 4'b0101, 32'hAABBCCDD);
        #1;
        checkValue("r1WrReady", 64'(reqReady), 64'h2);
        checkValue("r1WrBe", 64'(memWriteByteEnable), 64'h5);
        tick();
        checkValue("r1WrResp", 64'(respValid), 64'h2);
        checkValue("r1WrData", 64'(respData[2*DW-1 -: DW]), 64'd0);
        setReq(1, 1'b0, 4'd5, 4'h0, 32'h0);
        tick();
        checkValue("r1RdResp", 64'(respValid), 64'h2);
        checkValue("r1RdData", 64'(respData[2*DW-1 -: DW]), 64'h11BB33DD);
        checkValue("r0DataHeld", 64'(respData[DW-1:0]), 64'h11223344);

        // Contention from pointer 0: strict alternation.
        setReq(0, 1'b0, 4'd5, 4'h0, 32'h0);
        reqValid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp;
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checkValue("contendReady", 64'(reqReady), 64'(exp));
            tick();
            checkValue("contendResp", 64'(respValid), 64'(exp));
        end
        reqValid = 2'b00;
        tick();
        checkValue("idleResp", 64'(respValid), 64'd0);

        // Read-after-write across requesters.
        setReq(0, 1'b1, 4'd9, 4'hF, 32'h55);
        reqValid = 2'b01;
        tick();
        setReq(1, 1'b0, 4'd9, 4'h0, 32'h0);
        reqValid = 2'b10;
        #1;
        checkValue("rawReady", 64'(reqReady), 64'h2);
        tick();
        checkValue("rawResp", 64'(respValid), 64'h2);
        checkValue("rawData", 64'(respData[2*DW-1 -: DW]), 64'h55);

        // Zero byte-enable write is acknowledged but changes nothing.
        setReq(0, 1'b1, 4'd9, 4'h0, 32'hFFFFFFFF);
        reqValid = 2'b01;
        #1;
        checkValue("be0Ready", 64'(reqReady), 64'h1);
        tick();
        checkValue("be0Resp", 64'(respValid), 64'h1);
        setReq(0, 1'b0, 4'd9, 4'h0, 32'h0);
        tick();
        checkValue("be0Data", 64'(respData[DW-1:0]), 64'h55);

        // Reset after a grant: response dropped, pointer back to requester 0.
        reqValid = 2'b00;
        reset = 1'b1;
        tick();
        checkValue("rstResp", 64'(respValid), 64'd0);
        reset = 1'b0;
        reqValid = 2'b11;
        #1;
        waitReady();
        #1;
        checkValue("rstPointer", 64'(reqReady), 64'h1);
        reqValid = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
